// File: rtl/memreg_loader.sv
// memreg_loader: loads the memory-type registers from non-volatile memory.
// Reads NUM_REGS words plus a checksum word, writes each word to its register.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_reload        restart request, honoured only while idle or done
//   o_mem_rd_req    memory read request (level), o_mem_addr stable while high
//   i_mem_rd_ack    read acknowledge, i_mem_rd_data valid in the same cycle
//   o_mem_data      word driven to the registers' memory-data inputs
//   o_mem_wr_en     one-hot write pulse, bit n selects register n
//   o_busy          load in progress
//   o_done          load finished (sticky)
//   o_err_chk       checksum mismatch (sticky)
//   o_err_tmo       read acknowledge timeout (sticky)
module memreg_loader #(
    parameter int                 NUM_REGS  = 8,
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 4,
    parameter int                 BASE_ADDR = 0,
    parameter int                 TIMEOUT   = 255,
    parameter logic [DATA_W-1:0]  CHK_SEED  = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_reload,
    output logic                o_mem_rd_req,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic                i_mem_rd_ack,
    input  logic [DATA_W-1:0]   i_mem_rd_data,
    output logic [DATA_W-1:0]   o_mem_data,
    output logic [NUM_REGS-1:0] o_mem_wr_en,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err_chk,
    output logic                o_err_tmo
);

    localparam int IDX_W = $clog2(NUM_REGS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WRITE,
        CHECK,
        DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] acc;
    logic [15:0]       timer;
    logic              start;

    // IDLE always launches the auto-load; DONE relaunches on request.
    assign start = (state == IDLE) || ((state == DONE) && i_reload);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            acc          <= CHK_SEED;
            timer        <= '0;
            o_mem_rd_req <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_data   <= '0;
            o_mem_wr_en  <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err_chk    <= 1'b0;
            o_err_tmo    <= 1'b0;
        end else if (start) begin
            state        <= REQ;
            idx          <= '0;
            acc          <= CHK_SEED;
            timer        <= '0;
            o_mem_rd_req <= 1'b1;
            o_mem_addr   <= ADDR_W'(BASE_ADDR);
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_err_chk    <= 1'b0;
            o_err_tmo    <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (i_mem_rd_ack) begin
                        o_mem_data   <= i_mem_rd_data;
                        timer        <= '0;
                        o_mem_rd_req <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= CHECK;
                        end else begin
                            state       <= WRITE;
                            o_mem_wr_en <= NUM_REGS'(1) << idx;
                        end
                    end else if (timer == TMO_LAST) begin
                        // Abandon the load; remaining registers keep their presets.
                        timer        <= '0;
                        o_mem_rd_req <= 1'b0;
                        o_err_tmo    <= 1'b1;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b1;
                        state        <= DONE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                WRITE: begin
                    o_mem_wr_en  <= '0;
                    acc          <= acc ^ o_mem_data;
                    idx          <= idx + IDX_W'(1);
                    o_mem_addr   <= o_mem_addr + ADDR_W'(1);
                    o_mem_rd_req <= 1'b1;
                    state        <= REQ;
                end
                CHECK: begin
                    // o_mem_data holds the checksum word captured in REQ.
                    o_err_chk <= (acc != o_mem_data);
                    o_busy    <= 1'b0;
                    o_done    <= 1'b1;
                    state     <= DONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memreg_loader.sv
// tb_memreg_loader: directed bench for memreg_loader.
// Zero/multi-wait memory model, write log, immediate-assertion checks.
module tb_memreg_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_reload = 1'b0;
    logic       o_mem_rd_req;
    logic [3:0] o_mem_addr;
    logic       i_mem_rd_ack;
    logic [7:0] i_mem_rd_data;
    logic [7:0] o_mem_data;
    logic [7:0] o_mem_wr_en;
    logic       o_busy;
    logic       o_done;
    logic       o_err_chk;
    logic       o_err_tmo;

    memreg_loader #(
        .NUM_REGS (8),
        .DATA_W   (8),
        .ADDR_W   (4),
        .BASE_ADDR(0),
        .TIMEOUT  (255),
        .CHK_SEED (8'hA5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_reload     (i_reload),
        .o_mem_rd_req (o_mem_rd_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_rd_ack (i_mem_rd_ack),
        .i_mem_rd_data(i_mem_rd_data),
        .o_mem_data   (o_mem_data),
        .o_mem_wr_en  (o_mem_wr_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err_chk    (o_err_chk),
        .o_err_tmo    (o_err_tmo)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:15];
    int         delay = 0;
    logic       dead_en = 1'b0;
    logic [3:0] dead_addr = 4'd3;
    int         wcnt = 0;

    assign i_mem_rd_ack = o_mem_rd_req && (wcnt == delay)
                          && !(dead_en && (o_mem_addr == dead_addr));
    assign i_mem_rd_data = mem[o_mem_addr];

    always @(posedge clk) begin
        if (!o_mem_rd_req || i_mem_rd_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    logic [7:0] log_en [$];
    logic [7:0] log_d  [$];
    int         addr_glitch = 0;
    int         dead_cnt = 0;
    logic       prev_req = 1'b0;
    logic [3:0] prev_addr = 4'd0;

    always @(negedge clk) begin
        if (o_mem_wr_en != 8'd0) begin
            log_en.push_back(o_mem_wr_en);
            log_d.push_back(o_mem_data);
        end
        if (prev_req && o_mem_rd_req && (prev_addr != o_mem_addr))
            addr_glitch = addr_glitch + 1;
        if (o_mem_rd_req && dead_en && (o_mem_addr == dead_addr))
            dead_cnt = dead_cnt + 1;
        prev_req  = o_mem_rd_req;
        prev_addr = o_mem_addr;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_en.delete();
        log_d.delete();
    endtask

    task automatic pulse_reload();
        i_reload = 1'b1;
        @(negedge clk);
        i_reload = 1'b0;
    endtask

    task automatic run_to_done(output int cyc);
        cyc = 0;
        while (!o_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_writes(input string tag, input int n);
        chk({tag, "_wcnt"}, 64'(log_en.size()), 64'(n));
        for (int i = 0; i < n && i < log_en.size(); i++) begin
            chk({tag, "_wen"}, 64'(log_en[i]), 64'(1) << i);
            chk({tag, "_wdat"}, 64'(log_d[i]), 64'(mem[i]));
        end
    endtask

    logic [7:0] sum;
    int         cyc;
    int         k;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[i] = 8'((i + 1) * 17);
        sum = 8'hA5;
        for (int i = 0; i < 8; i++) sum = sum ^ mem[i];
        mem[8] = sum;

        // reset state
        #12;
        chk("rst_outs", 64'({o_mem_rd_req, o_mem_addr, o_mem_data,
                              o_mem_wr_en, o_busy, o_done,
                              o_err_chk, o_err_tmo}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // s1: auto-load, zero-wait
        @(negedge clk);
        chk("s1_busy", 64'(o_busy), 64'd1);
        chk("s1_addr0", 64'(o_mem_addr), 64'd0);
        run_to_done(cyc);
        chk("s1_cycles", 64'(cyc), 64'd18);
        check_writes("s1", 8);
        chk("s1_flags", 64'({o_done, o_busy, o_mem_rd_req,
                              o_err_chk, o_err_tmo}), 64'b10000);

        // s2: corrupted checksum word
        mem[8] = 8'h00;
        clear_log();
        pulse_reload();
        chk("s2_restart", 64'({o_done, o_busy}), 64'b01);
        run_to_done(cyc);
        chk("s2_cycles", 64'(cyc), 64'd18);
        check_writes("s2", 8);
        chk("s2_errchk", 64'(o_err_chk), 64'd1);
        chk("s2_done", 64'(o_done), 64'd1);
        mem[8] = sum;

        // s3: three wait cycles per read
        delay = 3;
        addr_glitch = 0;
        clear_log();
        pulse_reload();
        chk("s3_errclr", 64'(o_err_chk), 64'd0);
        run_to_done(cyc);
        chk("s3_cycles", 64'(cyc), 64'd45);
        chk("s3_addr_stable", 64'(addr_glitch), 64'd0);
        check_writes("s3", 8);
        chk("s3_flags", 64'({o_err_chk, o_err_tmo}), 64'd0);

        // s4: no ack at address 3
        delay = 0;
        dead_en = 1'b1;
        dead_cnt = 0;
        clear_log();
        pulse_reload();
        run_to_done(cyc);
        chk("s4_cycles", 64'(cyc), 64'd261);
        chk("s4_wait", 64'(dead_cnt), 64'd255);
        check_writes("s4", 3);
        chk("s4_flags", 64'({o_done, o_busy, o_mem_rd_req,
                              o_err_chk, o_err_tmo}), 64'b10001);

        // s5: reload mid-load ignored, then honoured in DONE
        dead_en = 1'b0;
        clear_log();
        pulse_reload();
        chk("s5_tmoclr", 64'(o_err_tmo), 64'd0);
        k = 0;
        while (!(o_mem_rd_req && o_mem_addr == 4'd4) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("s5_reach4", 64'(o_mem_rd_req && o_mem_addr == 4'd4), 64'd1);
        pulse_reload();
        run_to_done(cyc);
        repeat (3) @(negedge clk);
        check_writes("s5a", 8);
        chk("s5_idle", 64'({o_done, o_busy}), 64'b10);
        clear_log();
        pulse_reload();
        chk("s5_restart", 64'({o_done, o_busy}), 64'b01);
        run_to_done(cyc);
        chk("s5_cycles", 64'(cyc), 64'd18);
        check_writes("s5b", 8);

        // s6: reset during the write of register 5
        clear_log();
        pulse_reload();
        k = 0;
        while (!o_mem_wr_en[5] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("s6_reach5", 64'(o_mem_wr_en), 64'h20);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_outs", 64'({o_mem_rd_req, o_mem_addr, o_mem_data,
                                 o_mem_wr_en, o_busy, o_done,
                                 o_err_chk, o_err_tmo}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        @(negedge clk);
        chk("s6_restart", 64'({o_busy, o_mem_rd_req}), 64'b11);
        chk("s6_addr0", 64'(o_mem_addr), 64'd0);
        run_to_done(cyc);
        chk("s6_cycles", 64'(cyc), 64'd18);
        check_writes("s6", 8);
        chk("s6_flags", 64'({o_err_chk, o_err_tmo}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
